// File: rtl/wyswietlacz_multipleksowany_n.sv
// N-digit multiplexed common-anode seven-segment driver with a sequential
// shift-and-add-3 binary-to-BCD converter, load/ready handshake, leading-zero
// blanking, per-digit decimal points and overflow indication.
module wyswietlacz_multipleksowany_n #(
  parameter int unsigned LICZBA_CYFR       = 4,
  parameter int unsigned SZEROKOSC         = 14,
  parameter int unsigned OKRES_ODSWIEZANIA = 100000,
  parameter bit          WYGASZANIE_ZER    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SZEROKOSC-1:0]   wartosc,
  input  logic [LICZBA_CYFR-1:0] kropka,
  input  logic                   zapis,
  output logic                   gotowy,
  output logic [7:0]             seven_segmented_display,
  output logic [LICZBA_CYFR-1:0] zalaczony_wyswietlacz
);

  localparam int unsigned N    = LICZBA_CYFR;
  localparam int unsigned W    = SZEROKOSC;
  localparam int unsigned BcdW = 4 * N;
  localparam int unsigned CntW = $clog2(OKRES_ODSWIEZANIA);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BitW = $clog2(W + 1);

  function automatic int unsigned max_wartosc(input int unsigned cyfry);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < cyfry; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int unsigned MaxWartosc = max_wartosc(N);

  // Bits 7..1 = a..g, active low.
  function automatic logic [6:0] kod(input logic [3:0] n);
    case (n)
      4'd0:    kod = 7'b0000001;
      4'd1:    kod = 7'b1001111;
      4'd2:    kod = 7'b0010010;
      4'd3:    kod = 7'b0000110;
      4'd4:    kod = 7'b1001100;
      4'd5:    kod = 7'b0100100;
      4'd6:    kod = 7'b0100000;
      4'd7:    kod = 7'b0001111;
      4'd8:    kod = 7'b0000000;
      4'd9:    kod = 7'b0000100;
      default: kod = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {StBezczynny, StKonwersja, StZapis} stan_e;

  stan_e            stan_q, stan_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [BcdW-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [BitW-1:0]  licz_q, licz_d;
  logic [N-1:0]     dp_sh_q, dp_sh_d;
  logic             ovf_sh_q, ovf_sh_d;
  logic [BcdW-1:0]  disp_bcd_q, disp_bcd_d;
  logic [N-1:0]     disp_dp_q, disp_dp_d;
  logic             disp_ovf_q, disp_ovf_d;
  logic             gotowy_q, gotowy_d;
  logic [CntW-1:0]  odsw_q, odsw_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             akt_q, akt_d;
  logic [7:0]       seg_q, seg_d;
  logic [N-1:0]     en_q, en_d;
  logic [N-1:0]     wygas;
  logic             zera;
  logic [3:0]       nibble;

  // State and data registers, synchronous reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      stan_q     <= StBezczynny;
      bin_q      <= '0;
      bcd_q      <= '0;
      licz_q     <= '0;
      dp_sh_q    <= '0;
      ovf_sh_q   <= 1'b0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      disp_ovf_q <= 1'b0;
      gotowy_q   <= 1'b1;
      odsw_q     <= '0;
      idx_q      <= '0;
      akt_q      <= 1'b0;
      seg_q      <= 8'hFF;
      en_q       <= '1;
    end else begin
      stan_q     <= stan_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      licz_q     <= licz_d;
      dp_sh_q    <= dp_sh_d;
      ovf_sh_q   <= ovf_sh_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      disp_ovf_q <= disp_ovf_d;
      gotowy_q   <= gotowy_d;
      odsw_q     <= odsw_d;
      idx_q      <= idx_d;
      akt_q      <= akt_d;
      seg_q      <= seg_d;
      en_q       <= en_d;
    end
  end

  // Converter next-state logic.
  always_comb begin
    stan_d = stan_q;
    case (stan_q)
      StBezczynny: if (zapis) stan_d = StKonwersja;
      StKonwersja: if (licz_q == BitW'(1)) stan_d = StZapis;
      StZapis:     stan_d = StBezczynny;
      default:     stan_d = StBezczynny;
    endcase
  end

  // Ready is registered so it tracks the state the FSM is entering.
  always_comb begin
    gotowy_d = (stan_d == StBezczynny);
  end

  // Capture, shift-and-add-3 datapath and display register update.
  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    licz_d     = licz_q;
    dp_sh_d    = dp_sh_q;
    ovf_sh_d   = ovf_sh_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;
    disp_ovf_d = disp_ovf_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (stan_q)
      StBezczynny: begin
        if (zapis) begin
          bin_d    = wartosc;
          bcd_d    = '0;
          licz_d   = BitW'(W);
          dp_sh_d  = kropka;
          ovf_sh_d = ({{(32 - W){1'b0}}, wartosc} > MaxWartosc);
        end
      end
      StKonwersja: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        licz_d         = licz_q - BitW'(1);
      end
      StZapis: begin
        disp_bcd_d = bcd_q;
        disp_dp_d  = dp_sh_q;
        disp_ovf_d = ovf_sh_q;
      end
      default: ;
    endcase
  end

  // Refresh counter and digit index; index is "none" until the first wrap.
  always_comb begin
    odsw_d = odsw_q + CntW'(1);
    idx_d  = idx_q;
    akt_d  = akt_q;
    if (odsw_q == CntW'(OKRES_ODSWIEZANIA - 1)) begin
      odsw_d = '0;
      akt_d  = 1'b1;
      if (!akt_q || idx_q == IdxW'(N - 1)) idx_d = '0;
      else                                 idx_d = idx_q + IdxW'(1);
    end
  end

  // Digit i is blank when it and everything above it is zero with no DP.
  always_comb begin
    wygas = '0;
    zera  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      zera     = zera && (disp_bcd_q[4*i +: 4] == 4'd0) && !disp_dp_q[i];
      wygas[i] = WYGASZANIE_ZER && (i > 0) && zera;
    end
  end

  // Segment/enable pattern for the active digit, registered together.
  always_comb begin
    seg_d  = 8'hFF;
    en_d   = '1;
    nibble = disp_bcd_q[{idx_q, 2'b00} +: 4];
    if (akt_q) begin
      en_d[idx_q] = 1'b0;
      if (disp_ovf_q)        seg_d = 8'b11111101;
      else if (wygas[idx_q]) seg_d = 8'hFF;
      else                   seg_d = {kod(nibble), ~disp_dp_q[idx_q]};
    end
  end

  assign gotowy                  = gotowy_q;
  assign seven_segmented_display = seg_q;
  assign zalaczony_wyswietlacz   = en_q;

endmodule

// File: tb/tb_wyswietlacz_multipleksowany_n.sv
// Directed bench for the multiplexed display driver (N=4, W=14, refresh 4).
module tb_wyswietlacz_multipleksowany_n;

  localparam int N = 4;
  localparam int W = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  wartosc = '0;
  logic [N-1:0]  kropka = '0;
  logic          zapis = 1'b0;
  logic          gotowy;
  logic [7:0]    seg;
  logic [N-1:0]  en;

  int checks = 0;
  int failures = 0;

  wyswietlacz_multipleksowany_n #(
    .LICZBA_CYFR      (N),
    .SZEROKOSC        (W),
    .OKRES_ODSWIEZANIA(4),
    .WYGASZANIE_ZER   (1'b1)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .wartosc                (wartosc),
    .kropka                 (kropka),
    .zapis                  (zapis),
    .gotowy                 (gotowy),
    .seven_segmented_display(seg),
    .zalaczony_wyswietlacz  (en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (gotowy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic start(input logic [W-1:0] v, input logic [N-1:0] dp, output bit ok);
    wait_ready(ok);
    wartosc = v;
    kropka  = dp;
    zapis   = 1'b1;
    tick(1);
    zapis   = 1'b0;
  endtask

  task automatic grab(input logic [N-1:0] want_en, output logic [7:0] s, output bit ok);
    ok = 1'b0;
    s  = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (en === want_en) begin
        s  = seg;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (seg !== 8'hFF || en !== 4'hF || gotowy !== 1'b1) begin
      failures++;
      $display("FAIL reset_values seg=%b en=%b gotowy=%b want 11111111 1111 1", seg, en, gotowy);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (en !== 4'hF || seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_idx_none en=%b seg=%b want 1111 11111111", en, seg);
    end
    @(negedge clk);
    checks++;
    if (en !== 4'b1110 || seg !== 8'b00000011) begin
      failures++;
      $display("FAIL reset_first_digit en=%b seg=%b want 1110 00000011", en, seg);
    end
    tick(1);
  endtask

  task automatic test_load;
    logic [7:0] exp [4];
    logic [7:0] s;
    logic [3:0] we;
    bit ok;
    int lo;
    exp = '{8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};
    wait_ready(ok);
    wartosc = 14'd1234;
    kropka  = '0;
    zapis   = 1'b1;
    tick(1);
    zapis = 1'b0;
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gotowy === 1'b0) lo++;
      else break;
    end
    checks++;
    if (!ok || lo != 15) begin
      failures++;
      $display("FAIL load_busy_len got=%0d want=15", lo);
    end
    tick(2);
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin
        failures++;
        $display("FAIL load_1234_digit%0d seg=%b found=%0d want=%b", d, s, ok, exp[d]);
      end
    end
  endtask

  task automatic test_leading_zeros;
    logic [7:0] exp [4];
    logic [7:0] s;
    logic [3:0] we;
    bit ok;
    start(14'd7, 4'b0000, ok);
    wait_ready(ok);
    tick(2);
    exp = '{8'b00011111, 8'hFF, 8'hFF, 8'hFF};
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin
        failures++;
        $display("FAIL blank_7_digit%0d seg=%b found=%0d want=%b", d, s, ok, exp[d]);
      end
    end
    start(14'd5, 4'b0010, ok);
    wait_ready(ok);
    tick(2);
    exp = '{8'b01001001, 8'b00000010, 8'hFF, 8'hFF};
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin
        failures++;
        $display("FAIL dp_5_digit%0d seg=%b found=%0d want=%b", d, s, ok, exp[d]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] s;
    logic [3:0] we;
    bit ok;
    start(14'd10000, 4'b1111, ok);
    wait_ready(ok);
    tick(2);
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== 8'b11111101) begin
        failures++;
        $display("FAIL ovf_10000_digit%0d seg=%b found=%0d want=11111101", d, s, ok);
      end
    end
    start(14'd9999, 4'b0000, ok);
    wait_ready(ok);
    tick(2);
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== 8'b00001001) begin
        failures++;
        $display("FAIL max_9999_digit%0d seg=%b found=%0d want=00001001", d, s, ok);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [4];
    logic [7:0] s;
    logic [3:0] we;
    bit ok;
    start(14'd1234, 4'b0000, ok);
    tick(3);
    wartosc = 14'd5678;
    zapis   = 1'b1;
    tick(1);
    zapis = 1'b0;
    wait_ready(ok);
    tick(2);
    checks++;
    if (!ok || gotowy !== 1'b1) begin
      failures++;
      $display("FAIL busy_no_queue gotowy=%b want 1", gotowy);
    end
    exp = '{8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin
        failures++;
        $display("FAIL busy_1234_digit%0d seg=%b found=%0d want=%b", d, s, ok, exp[d]);
      end
    end
    // Reload 1234, then fire 5678 in the very cycle gotowy rises.
    start(14'd1234, 4'b0000, ok);
    tick(1);
    wait_ready(ok);
    wartosc = 14'd5678;
    zapis   = 1'b1;
    tick(1);
    zapis = 1'b0;
    checks++;
    if (!ok || gotowy !== 1'b0) begin
      failures++;
      $display("FAIL accept_on_rise gotowy=%b want 0", gotowy);
    end
    wait_ready(ok);
    tick(2);
    exp = '{8'b00000001, 8'b00011111, 8'b01000001, 8'b01001001};
    for (int d = 0; d < 4; d++) begin
      we = ~(4'b0001 << d);
      grab(we, s, ok);
      checks++;
      if (!ok || s !== exp[d]) begin
        failures++;
        $display("FAIL rise_5678_digit%0d seg=%b found=%0d want=%b", d, s, ok, exp[d]);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] exp [4];
    logic [7:0] s;
    logic [3:0] we;
    bit ok;
    start(14'd4321, 4'b0000, ok);
    tick(5);
    rst = 1'b1;
    tick(2);
    checks++;
    if (seg !== 8'hFF || en !== 4'hF || gotowy !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset seg=%b en=%b gotowy=%b want 11111111 1111 1", seg, en, gotowy);
    end
    rst = 1'b0;
    tick(2);
    exp = '{8'b00000011, 8'hFF, 8'hFF, 8'hFF};
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        we = ~(4'b0001 << d);
        grab(we, s, ok);
        checks++;
        if (!ok || s !== exp[d]) begin
          failures++;
          $display("FAIL abort_zero_digit%0d seg=%b found=%0d want=%b", d, s, ok, exp[d]);
        end
      end
    end
    checks++;
    if (gotowy !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle gotowy=%b want 1", gotowy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_leading_zeros();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
